// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg
// Shared definitions for the alu_cmd_driver slice: default widths, the
// decoded opcode values (low 3 bits of the 32-bit opcode) and the FSM
// state type used by the top level.
package alu_cmd_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_REGS = 8;
  localparam int unsigned DEF_ID_W     = 32;
  localparam int unsigned OPCODE_W     = 32;
  localparam int unsigned OP_DEC_W     = 3;

  localparam logic [OP_DEC_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_DEC_W-1:0] OP_WRITE = 3'd1;
  localparam logic [OP_DEC_W-1:0] OP_ADD   = 3'd2;
  localparam logic [OP_DEC_W-1:0] OP_READ  = 3'd3;
  localparam logic [OP_DEC_W-1:0] OP_SUM   = 3'd4;

  typedef enum logic {
    S_IDLE,
    S_ACC
  } state_t;

endpackage

// File: rtl/alu_cmd_regfile.sv
// alu_cmd_regfile
// NUM_REGS x DATA_W operand store with two combinational read ports and
// one synchronous write port; asynchronous active-low clear.
//   clock, reset        : rising-edge clock, async active-low clear
//   we, waddr, wdata    : write port, takes effect at the rising edge
//   raddr_a / rdata_a   : combinational read port A
//   raddr_b / rdata_b   : combinational read port B
module alu_cmd_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  input  logic [IDX_W-1:0]  raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
// Command-driven ALU engine. One command per valid/ready handshake, operands
// held in an internal register file. WRITE/READ/ADD/NOP and illegal opcodes
// respond in one cycle; SUM walks in[] registers from srcA (wrapping), one
// element per cycle, then writes reg[id] and responds.
//   clock, reset                 : rising-edge clock, async active-low reset
//   cmd_valid / cmd_ready        : command handshake
//   opcode, id, addr, in         : command fields (addr = {srcB, srcA})
//   rsp_valid                    : one-cycle response pulse
//   rsp_id, out, ovf, err        : response fields, held between responses
module alu_cmd_driver
  import alu_cmd_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ID_W     = DEF_ID_W,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [ID_W-1:0]      id,
  input  logic [2*IDX_W-1:0]   addr,
  input  logic [DATA_W-1:0]    in,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [DATA_W-1:0]    out,
  output logic                 ovf,
  output logic                 err
);

  state_t              state_q, state_d;
  logic                ready_q;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    dst_q, dst_d;
  logic [ID_W-1:0]     tag_q, tag_d;
  logic                cy_q, cy_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic                we;
  logic [IDX_W-1:0]    waddr;
  logic [DATA_W-1:0]   wdata;
  logic [IDX_W-1:0]    raddr_a;
  logic [DATA_W-1:0]   rdata_a, rdata_b;

  logic                respond;
  logic [ID_W-1:0]     res_id;
  logic [DATA_W-1:0]   res_out;
  logic                res_ovf;
  logic                res_err;

  logic                accept;
  logic [OP_DEC_W-1:0] op_dec;
  logic                op_bad;
  logic [IDX_W-1:0]    id_idx, src_a, src_b;
  logic [DATA_W:0]     add_ab;
  logic [DATA_W:0]     acc_sum;

  assign accept  = cmd_valid && ready_q;
  assign op_dec  = opcode[OP_DEC_W-1:0];
  // Nonzero upper opcode bits are not a defined command, so they are
  // reported the same way as opcodes 5-7.
  assign op_bad  = (|opcode[OPCODE_W-1:OP_DEC_W]) || (op_dec > OP_SUM);
  assign id_idx  = id[IDX_W-1:0];
  assign src_a   = addr[IDX_W-1:0];
  assign src_b   = addr[2*IDX_W-1:IDX_W];

  // Port A is shared: the walking pointer owns it while accumulating.
  assign raddr_a = (state_q == S_ACC) ? ptr_q : src_a;

  assign add_ab  = {1'b0, rdata_a} + {1'b0, rdata_b};
  assign acc_sum = {1'b0, acc_q} + {1'b0, rdata_a};

  alu_cmd_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (raddr_a),
    .raddr_b (src_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    dst_d   = dst_q;
    tag_d   = tag_q;
    cy_d    = cy_q;

    we      = 1'b0;
    waddr   = id_idx;
    wdata   = '0;

    respond = 1'b0;
    res_id  = id;
    res_out = '0;
    res_ovf = 1'b0;
    res_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_bad) begin
            respond = 1'b1;
            res_err = 1'b1;
          end else begin
            case (op_dec)
              OP_WRITE: begin
                we      = 1'b1;
                wdata   = in;
                respond = 1'b1;
                res_out = in;
              end
              OP_ADD: begin
                we      = 1'b1;
                wdata   = add_ab[DATA_W-1:0];
                respond = 1'b1;
                res_out = add_ab[DATA_W-1:0];
                res_ovf = add_ab[DATA_W];
              end
              OP_READ: begin
                respond = 1'b1;
                res_out = rdata_a;
              end
              OP_SUM: begin
                if (in == '0) begin
                  we      = 1'b1;
                  wdata   = '0;
                  respond = 1'b1;
                end else begin
                  state_d = S_ACC;
                  acc_d   = '0;
                  cy_d    = 1'b0;
                  cnt_d   = in;
                  ptr_d   = src_a;
                  dst_d   = id_idx;
                  tag_d   = id;
                end
              end
              default: begin
                respond = 1'b1;
              end
            endcase
          end
        end
      end
      S_ACC: begin
        acc_d = acc_sum[DATA_W-1:0];
        cy_d  = cy_q | acc_sum[DATA_W];
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
        // Last element: commit the running sum in the same cycle it is formed.
        if (cnt_q == DATA_W'(1)) begin
          we      = 1'b1;
          waddr   = dst_q;
          wdata   = acc_sum[DATA_W-1:0];
          state_d = S_IDLE;
          respond = 1'b1;
          res_id  = tag_q;
          res_out = acc_sum[DATA_W-1:0];
          res_ovf = cy_q | acc_sum[DATA_W];
        end
      end
    endcase

    rsp_valid_d = respond;
    rsp_id_d    = respond ? res_id  : rsp_id_q;
    out_d       = respond ? res_out : out_q;
    ovf_d       = respond ? res_ovf : ovf_q;
    err_d       = respond ? res_err : err_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      dst_q       <= '0;
      tag_q       <= '0;
      cy_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == S_IDLE);
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      dst_q       <= dst_d;
      tag_q       <= tag_d;
      cy_q        <= cy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;
  import alu_cmd_pkg::*;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] opcode;
  logic [31:0] id;
  logic [5:0]  addr;
  logic [31:0] in_data;
  logic        rsp_valid;
  logic [31:0] rsp_id;
  logic [31:0] out_data;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_cmd_driver #(
    .DATA_W   (32),
    .NUM_REGS (8),
    .ID_W     (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .opcode    (opcode),
    .id        (id),
    .addr      (addr),
    .in        (in_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .out       (out_data),
    .ovf       (ovf),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Drives one command; returns one cycle after its acceptance edge (#1 after).
  task automatic drive_cmd(input logic [31:0] op, input logic [31:0] cid,
                           input logic [2:0] sa, input logic [2:0] sb,
                           input logic [31:0] din);
    int unsigned waited;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: got cmd_ready=%b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    opcode    = op;
    id        = cid;
    addr      = {sb, sa};
    in_data   = din;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_out: got %h expected 0", out_data); end
    checks++; if (rsp_id !== 32'd0) begin errors++; $display("FAIL rst_rsp_id: got %h expected 0", rsp_id); end
    checks++; if (ovf !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_flags: got ovf=%b err=%b expected 0 0", ovf, err); end
    reset = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_before_edge: got %b expected 0", cmd_ready); end
    @(posedge clock); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after_edge: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write;
    drive_cmd(32'(OP_WRITE), 32'd1, 3'd0, 3'd0, 32'd5);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr1_valid: got %b expected 1", rsp_valid); end
    checks++; if (out_data !== 32'd5) begin errors++; $display("FAIL wr1_out: got %h expected 5", out_data); end
    checks++; if (rsp_id !== 32'd1) begin errors++; $display("FAIL wr1_id: got %h expected 1", rsp_id); end
    drive_cmd(32'(OP_WRITE), 32'd2, 3'd0, 3'd0, 32'd6);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr2_valid: got %b expected 1", rsp_valid); end
    checks++; if (out_data !== 32'd6) begin errors++; $display("FAIL wr2_out: got %h expected 6", out_data); end
    checks++; if (rsp_id !== 32'd2) begin errors++; $display("FAIL wr2_id: got %h expected 2", rsp_id); end
    @(posedge clock); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_pulse: got %b expected 0", rsp_valid); end
    checks++; if (out_data !== 32'd6 || rsp_id !== 32'd2) begin errors++; $display("FAIL wr_hold: got out=%h id=%h expected 6 2", out_data, rsp_id); end
  endtask

  task automatic test_add;
    drive_cmd(32'(OP_ADD), 32'd3, 3'd1, 3'd2, 32'd0);
    checks++; if (rsp_valid !== 1'b1 || out_data !== 32'd11) begin errors++; $display("FAIL add_out: got v=%b out=%h expected 1 11", rsp_valid, out_data); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b expected 0", ovf); end
    drive_cmd(32'(OP_READ), 32'd7, 3'd3, 3'd0, 32'd0);
    checks++; if (out_data !== 32'd11 || rsp_id !== 32'd7) begin errors++; $display("FAIL read3: got out=%h id=%h expected 11 7", out_data, rsp_id); end
    // destination aliases srcA: old reg1 (5) + reg2 (6)
    drive_cmd(32'(OP_ADD), 32'd1, 3'd1, 3'd2, 32'd0);
    checks++; if (out_data !== 32'd11) begin errors++; $display("FAIL add_alias: got %h expected 11", out_data); end
    drive_cmd(32'(OP_READ), 32'd0, 3'd1, 3'd0, 32'd0);
    checks++; if (out_data !== 32'd11) begin errors++; $display("FAIL read1_alias: got %h expected 11", out_data); end
  endtask

  task automatic test_overflow;
    drive_cmd(32'(OP_WRITE), 32'd0, 3'd0, 3'd0, 32'hFFFF_FFFF);
    drive_cmd(32'(OP_WRITE), 32'd1, 3'd0, 3'd0, 32'd1);
    drive_cmd(32'(OP_ADD), 32'd2, 3'd0, 3'd1, 32'd0);
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL ovf_out: got %h expected 0", out_data); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    drive_cmd(32'(OP_READ), 32'd2, 3'd2, 3'd0, 32'd0);
    checks++; if (out_data !== 32'd0 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_read: got out=%h ovf=%b expected 0 0", out_data, ovf); end
  endtask

  task automatic test_sum;
    int lat;
    int ready_low;
    drive_cmd(32'(OP_WRITE), 32'd6, 3'd0, 3'd0, 32'd10);
    drive_cmd(32'(OP_WRITE), 32'd7, 3'd0, 3'd0, 32'd20);
    drive_cmd(32'(OP_WRITE), 32'd0, 3'd0, 3'd0, 32'd3);
    drive_cmd(32'(OP_SUM), 32'd5, 3'd6, 3'd0, 32'd3);
    checks++; if (out_data !== 32'd3) begin errors++; $display("FAIL sum_hold_out: got %h expected 3", out_data); end
    lat = 0; ready_low = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      if (cmd_ready === 1'b0) ready_low++;
      @(posedge clock); #1;
      lat++;
    end
    // rsp registered at the 3rd edge after acceptance: 4th cycle counting the acceptance cycle
    checks++; if (lat != 3) begin errors++; $display("FAIL sum_latency: got %0d expected 3", lat); end
    checks++; if (ready_low != 3) begin errors++; $display("FAIL sum_ready_low: got %0d expected 3", ready_low); end
    checks++; if (out_data !== 32'd33 || rsp_id !== 32'd5) begin errors++; $display("FAIL sum_out: got out=%h id=%h expected 21 5", out_data, rsp_id); end
    checks++; if (cmd_ready !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL sum_end: got ready=%b ovf=%b expected 1 0", cmd_ready, ovf); end
    drive_cmd(32'(OP_READ), 32'd0, 3'd5, 3'd0, 32'd0);
    checks++; if (out_data !== 32'd33) begin errors++; $display("FAIL sum_read5: got %h expected 21", out_data); end
    // wrapped SUM with carry: reg7=FFFFFFFF + reg0=3
    drive_cmd(32'(OP_WRITE), 32'd7, 3'd0, 3'd0, 32'hFFFF_FFFF);
    drive_cmd(32'(OP_SUM), 32'd4, 3'd7, 3'd0, 32'd2);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    checks++; if (lat != 2) begin errors++; $display("FAIL sum2_latency: got %0d expected 2", lat); end
    checks++; if (out_data !== 32'd2 || ovf !== 1'b1) begin errors++; $display("FAIL sum2_out: got out=%h ovf=%b expected 2 1", out_data, ovf); end
    drive_cmd(32'(OP_SUM), 32'd5, 3'd6, 3'd0, 32'd0);
    checks++; if (rsp_valid !== 1'b1 || out_data !== 32'd0 || ovf !== 1'b0) begin errors++; $display("FAIL sum0: got v=%b out=%h ovf=%b expected 1 0 0", rsp_valid, out_data, ovf); end
    checks++; if (rsp_id !== 32'd5) begin errors++; $display("FAIL sum0_id: got %h expected 5", rsp_id); end
    drive_cmd(32'(OP_READ), 32'd0, 3'd5, 3'd0, 32'd0);
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL sum0_reg: got %h expected 0", out_data); end
  endtask

  task automatic test_illegal;
    drive_cmd(32'd6, 32'd6, 3'd1, 3'd2, 32'd99);
    checks++; if (rsp_valid !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL ill_err: got v=%b err=%b expected 1 1", rsp_valid, err); end
    checks++; if (out_data !== 32'd0 || ovf !== 1'b0 || rsp_id !== 32'd6) begin errors++; $display("FAIL ill_fields: got out=%h ovf=%b id=%h expected 0 0 6", out_data, ovf, rsp_id); end
    drive_cmd(32'(OP_READ), 32'd1, 3'd6, 3'd0, 32'd0);
    checks++; if (out_data !== 32'd10 || err !== 1'b0) begin errors++; $display("FAIL ill_nochange: got out=%h err=%b expected a 0", out_data, err); end
  endtask

  task automatic test_back_to_back;
    wait_ready_b2b: begin end
    cmd_valid = 1'b1; opcode = 32'(OP_WRITE); id = 32'd4; addr = 6'd0; in_data = 32'd77;
    @(posedge clock); #1;
    checks++; if (rsp_valid !== 1'b1 || out_data !== 32'd77 || rsp_id !== 32'd4) begin errors++; $display("FAIL b2b_wr: got v=%b out=%h id=%h expected 1 4d 4", rsp_valid, out_data, rsp_id); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", cmd_ready); end
    opcode = 32'(OP_READ); id = 32'd9; addr = {3'd0, 3'd4}; in_data = 32'd0;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || out_data !== 32'd77 || rsp_id !== 32'd9) begin errors++; $display("FAIL b2b_rd: got v=%b out=%h id=%h expected 1 4d 9", rsp_valid, out_data, rsp_id); end
  endtask

  task automatic test_reset_mid_sum;
    int stray;
    drive_cmd(32'(OP_WRITE), 32'd3, 3'd0, 3'd0, 32'd7);
    drive_cmd(32'(OP_SUM), 32'd4, 3'd0, 3'd0, 32'd4);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got v=%b ready=%b expected 0 0", rsp_valid, cmd_ready); end
    checks++; if (out_data !== 32'd0 || rsp_id !== 32'd0 || ovf !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_out: got out=%h id=%h ovf=%b err=%b expected 0", out_data, rsp_id, ovf, err); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (rsp_valid === 1'b1) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL mid_rst_stray: got %0d expected 0", stray); end
    for (int r = 0; r < 8; r++) begin
      drive_cmd(32'(OP_READ), 32'(r), 3'(r), 3'd0, 32'd0);
      checks++; if (rsp_valid !== 1'b1 || out_data !== 32'd0) begin errors++; $display("FAIL mid_rst_reg%0d: got v=%b out=%h expected 1 0", r, rsp_valid, out_data); end
    end
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; opcode = '0; id = '0; addr = '0; in_data = '0;
    test_reset();
    test_write();
    test_add();
    test_overflow();
    test_sum();
    test_illegal();
    test_back_to_back();
    test_reset_mid_sum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
